// File: rtl/dbi_tx_pkg.sv
// Shared definitions for the DBI TX scheduler: FSM states, control-mode codes,
// DBI command bytes and the stall-length helper.
package dbi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONF_TX   = 3'd1,
        ST_RST_STALL = 3'd2,
        ST_WIN_COL   = 3'd3,
        ST_WIN_ROW   = 3'd4,
        ST_STREAM_TX = 3'd5,
        ST_SLP_STALL = 3'd6
    } state_t;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_CONF   = 2'd1;
    localparam logic [1:0] MODE_STREAM = 2'd2;

    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_NOP    = 8'h00;

    // A stall always lasts at least one cycle, even for tiny clock settings.
    function automatic int stall_cycles(input int clk_hz, input int ms);
        int c;
        c = clk_hz / 1000 * ms;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/dbi_stall_timer.sv
// Loadable down-counter used for the post-reset (and optional post-SLPOUT) stalls.
// done is high whenever the count has reached zero.
module dbi_stall_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/dbi_tx_sched.sv
// DBI TX scheduler: arbitrates config transactions, HW-reset stall and windowed
// pixel streaming onto the DBI TX PHY. Optional SLPOUT stall: DBI_TX_SLP_STALL_EN.
module dbi_tx_sched
    import dbi_tx_pkg::*;
#(
    parameter int INTERNAL_CLK  = 125000000,
    parameter int DBI_IF_D_W    = 8,
    parameter int BYTES_PER_PXL = 2,
    parameter int WIN_W         = 16,
    parameter int RST_STALL_MS  = 120,
    parameter int SLP_STALL_MS  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            dbi_ctrl_mode_i,
    input  logic [DBI_IF_D_W-1:0] dbi_mem_com_i,
    input  logic [WIN_W-1:0]      win_col_s_i,
    input  logic [WIN_W-1:0]      win_col_e_i,
    input  logic [WIN_W-1:0]      win_row_s_i,
    input  logic [WIN_W-1:0]      win_row_e_i,
    input  logic                  tx_type_rw_i,
    input  logic                  tx_type_hrst_i,
    input  logic [2:0]            tx_type_dat_amt_i,
    input  logic                  tx_type_vld_i,
    output logic                  tx_type_rdy_o,
    input  logic [DBI_IF_D_W-1:0] tx_com_i,
    input  logic                  tx_com_vld_i,
    output logic                  tx_com_rdy_o,
    input  logic [DBI_IF_D_W-1:0] tx_data_i,
    input  logic                  tx_data_vld_i,
    output logic                  tx_data_rdy_o,
    input  logic [DBI_IF_D_W-1:0] pxl_d_i,
    input  logic                  pxl_vld_i,
    output logic                  pxl_rdy_o,
    input  logic                  dtp_tx_rdy_i,
    output logic                  dtp_dbi_hrst_o,
    output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o,
    output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o,
    output logic                  dtp_tx_last_o,
    output logic                  dtp_tx_no_dat_o,
    output logic                  dtp_tx_vld_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  win_err_o
);

    localparam int RST_CYC = stall_cycles(INTERNAL_CLK, RST_STALL_MS);
`ifdef DBI_TX_SLP_STALL_EN
    localparam int SLP_CYC = stall_cycles(INTERNAL_CLK, SLP_STALL_MS);
    localparam int MAX_CYC = (RST_CYC > SLP_CYC) ? RST_CYC : SLP_CYC;
`else
    localparam int MAX_CYC = RST_CYC;
`endif
    localparam int STALL_W = $clog2(MAX_CYC + 1);
    // Enough bits for a full-range window times bytes-per-pixel.
    localparam int FRM_W   = 2 * WIN_W + $clog2(BYTES_PER_PXL);

    state_t               state, state_n;
    logic [2:0]           conf_cnt;
    logic [1:0]           beat_idx;
    logic [FRM_W-1:0]     frm_cnt;
    logic [FRM_W-1:0]     frm_total;
    logic [WIN_W-1:0]     cs_q, ce_q, rs_q, re_q;
    logic [WIN_W:0]       span_c, span_r;
    logic                 win_ok, start_conf, start_win, beat, amt0;
    logic                 tmr_load, tmr_en, tmr_done;
    logic [STALL_W-1:0]   tmr_val;
    logic                 unused_rw;

    assign unused_rw = tx_type_rw_i;

    // Coordinates go out MSB byte first: start hi, start lo, end hi, end lo.
    function automatic logic [DBI_IF_D_W-1:0] win_byte(input logic [WIN_W-1:0] s,
                                                      input logic [WIN_W-1:0] e,
                                                      input logic [1:0]       idx);
        logic [15:0] v;
        v = idx[1] ? 16'(e) : 16'(s);
        return idx[0] ? DBI_IF_D_W'(v[7:0]) : DBI_IF_D_W'(v[15:8]);
    endfunction

    assign win_ok     = (win_col_e_i >= win_col_s_i) && (win_row_e_i >= win_row_s_i);
    assign span_c     = {1'b0, win_col_e_i} - {1'b0, win_col_s_i} + {{WIN_W{1'b0}}, 1'b1};
    assign span_r     = {1'b0, win_row_e_i} - {1'b0, win_row_s_i} + {{WIN_W{1'b0}}, 1'b1};
    assign frm_total  = FRM_W'(span_c) * FRM_W'(span_r) * FRM_W'(BYTES_PER_PXL);
    assign start_conf = (state == ST_IDLE) && (dbi_ctrl_mode_i == MODE_CONF) && tx_type_vld_i;
    assign start_win  = (state == ST_IDLE) && !start_conf && (dbi_ctrl_mode_i == MODE_STREAM)
                        && pxl_vld_i && win_ok;
    assign amt0       = (tx_type_dat_amt_i == 3'd0);
    assign beat       = dtp_tx_vld_o & dtp_tx_rdy_i;
    assign busy_o     = (state != ST_IDLE);

    dbi_stall_timer #(.CNT_W(STALL_W)) u_stall_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            conf_cnt <= 3'd0;
            beat_idx <= 2'd0;
            frm_cnt  <= '0;
        end else begin
            state <= state_n;
            if (start_conf)
                conf_cnt <= tx_type_dat_amt_i - 3'd1;
            else if (state == ST_CONF_TX && beat && !dtp_tx_last_o)
                conf_cnt <= conf_cnt - 3'd1;
            if (start_win) begin
                frm_cnt  <= frm_total - FRM_W'(1);
                beat_idx <= 2'd0;
            end else if ((state == ST_WIN_COL || state == ST_WIN_ROW) && beat) begin
                beat_idx <= beat_idx + 2'd1;
            end else if (state == ST_STREAM_TX && beat && !dtp_tx_last_o) begin
                frm_cnt <= frm_cnt - FRM_W'(1);
            end
        end
    end

    // The frame runs on a latched window so host reprogramming cannot disturb it.
    always_ff @(posedge clk) begin
        if (start_win) begin
            cs_q <= win_col_s_i;
            ce_q <= win_col_e_i;
            rs_q <= win_row_s_i;
            re_q <= win_row_e_i;
        end
    end

    always_comb begin
        state_n          = state;
        dtp_dbi_hrst_o   = 1'b0;
        dtp_tx_cmd_typ_o = '0;
        dtp_tx_cmd_dat_o = '0;
        dtp_tx_last_o    = 1'b0;
        dtp_tx_no_dat_o  = 1'b0;
        dtp_tx_vld_o     = 1'b0;
        tx_type_rdy_o    = 1'b0;
        tx_com_rdy_o     = 1'b0;
        tx_data_rdy_o    = 1'b0;
        pxl_rdy_o        = 1'b0;
        frame_done_o     = 1'b0;
        win_err_o        = 1'b0;
        tmr_load         = 1'b0;
        tmr_en           = 1'b0;
        tmr_val          = '0;
        case (state)
            ST_IDLE: begin
                if (start_conf)
                    state_n = ST_CONF_TX;
                else if (start_win)
                    state_n = ST_WIN_COL;
                else if (dbi_ctrl_mode_i == MODE_STREAM && pxl_vld_i && !win_ok)
                    win_err_o = 1'b1;
            end
            ST_CONF_TX: begin
                dtp_tx_vld_o     = tx_type_vld_i & (tx_type_hrst_i |
                                   (tx_com_vld_i & (amt0 | tx_data_vld_i)));
                dtp_tx_last_o    = (conf_cnt == 3'd0) | tx_type_hrst_i | amt0;
                dtp_tx_no_dat_o  = amt0 | tx_type_hrst_i;
                dtp_dbi_hrst_o   = tx_type_vld_i & tx_type_hrst_i;
                dtp_tx_cmd_typ_o = tx_type_hrst_i ? DBI_IF_D_W'(CMD_NOP) : tx_com_i;
                dtp_tx_cmd_dat_o = (tx_type_hrst_i | amt0) ? '0 : tx_data_i;
                tx_type_rdy_o    = dtp_tx_rdy_i & dtp_tx_last_o;
                tx_com_rdy_o     = tx_type_rdy_o & ~tx_type_hrst_i;
                tx_data_rdy_o    = dtp_tx_rdy_i & ~amt0 & ~tx_type_hrst_i;
                if (tx_type_vld_i && tx_type_rdy_o) begin
                    if (tx_type_hrst_i) begin
                        state_n  = ST_RST_STALL;
                        tmr_load = 1'b1;
                        tmr_val  = STALL_W'(RST_CYC - 1);
`ifdef DBI_TX_SLP_STALL_EN
                    end else if (tx_com_i == DBI_IF_D_W'(CMD_SLPOUT)) begin
                        state_n  = ST_SLP_STALL;
                        tmr_load = 1'b1;
                        tmr_val  = STALL_W'(SLP_CYC - 1);
`endif
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_RST_STALL: begin
                tmr_en = 1'b1;
                if (tmr_done) state_n = ST_IDLE;
            end
`ifdef DBI_TX_SLP_STALL_EN
            ST_SLP_STALL: begin
                tmr_en = 1'b1;
                if (tmr_done) state_n = ST_IDLE;
            end
`endif
            ST_WIN_COL, ST_WIN_ROW: begin
                dtp_tx_vld_o  = 1'b1;
                dtp_tx_last_o = (beat_idx == 2'd3);
                if (state == ST_WIN_COL) begin
                    dtp_tx_cmd_typ_o = DBI_IF_D_W'(CMD_CASET);
                    dtp_tx_cmd_dat_o = win_byte(cs_q, ce_q, beat_idx);
                    if (beat && dtp_tx_last_o) state_n = ST_WIN_ROW;
                end else begin
                    dtp_tx_cmd_typ_o = DBI_IF_D_W'(CMD_RASET);
                    dtp_tx_cmd_dat_o = win_byte(rs_q, re_q, beat_idx);
                    if (beat && dtp_tx_last_o) state_n = ST_STREAM_TX;
                end
            end
            ST_STREAM_TX: begin
                dtp_tx_vld_o     = pxl_vld_i;
                dtp_tx_cmd_typ_o = dbi_mem_com_i;
                dtp_tx_cmd_dat_o = pxl_d_i;
                dtp_tx_last_o    = (frm_cnt == '0);
                pxl_rdy_o        = dtp_tx_rdy_i;
                if (beat && dtp_tx_last_o) begin
                    frame_done_o = 1'b1;
                    state_n      = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
